dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory of the 16-bit MIPS core between requester 0 (CPU load/store
//  path) and requester 1 (loader/DMA), using round-robin arbitration with optional locked bursts.
//  Read data is pipelined back to the requester that issued it. A saturating counter records
//  CPU stall cycles for the bench.
// PARAMETERS
//  ADDR_W     16  address width, both requesters and memory
//  DATA_W     16  data width
//  BURST_MAX  4   max accepted beats per locked burst (>=1)
// PORTS
//  clk               in   1       clock, all state on rising edge
//  reset             in   1       asynchronous, active-low reset (0 = reset asserted)
//  reqN_valid        in   1       N=0,1: request present; must not depend on reqN_ready
//  reqN_ready        out  1       request accepted this cycle when valid&&ready
//  reqN_we           in   1       1 = write, 0 = read
//  reqN_lock         in   1       1 = keep ownership after this beat
//  reqN_addr         in   ADDR_W  word address
//  reqN_wdata        in   DATA_W  write data
//  rspN_valid        out  1       read data for requester N, one-cycle pulse
//  rspN_rdata        out  DATA_W  read data (= mem_rdata)
//  mem_en            out  1       memory access this cycle
//  mem_we            out  1       memory write enable
//  mem_addr          out  ADDR_W  memory address
//  mem_wdata         out  DATA_W  memory write data
//  mem_rdata         in   DATA_W  synchronous read data, valid 1 cycle after mem_en&&!mem_we
//  grant_id          out  1       registered owner of the last accepted beat
//  busy              out  1       1 while in OWN0/OWN1
//  stall_clr         in   1       synchronous clear of stall_cnt
//  stall_cnt         out  16      cycles with req0_valid && !req0_ready, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, last=1 (requester 0 wins first tie), beat_cnt=0,
//    rsp0/1_valid=0, grant_id=0, stall_cnt=0. A read in flight is dropped, with no response.
//  - At most one reqN_ready is high per cycle. ready is combinational from state, last, and valids.
//  - IDLE: only one valid -> that requester is ready. Both valid -> requester != last is ready.
//  - OWNn: only requester n can be ready (ready=valid_n); the other requester's ready=0.
//  - Accept (valid&&ready): the same cycle, mem_en=1 and mem_we/addr/wdata are muxed from the
//    winner. No accept -> mem_en=0, mem_we=0, other mem outputs don't-care (drive 0).
//    On accept: last<=winner and grant_id<=winner.
//  - Read response: on a read accept in cycle t, rspN_valid=1 in cycle t+1 for the same N, with
//    rspN_rdata=mem_rdata. Throughput is 1 access/cycle, and a response may coincide with a new accept.
//    Writes produce no response.
//  - Bursts: beat_cnt counts accepted beats of the current ownership.
//    Accept with lock=1 and beat_cnt+1 < BURST_MAX -> next state OWNn, beat_cnt+1.
//    Accept with lock=0, or the BURST_MAX-th beat -> next state IDLE, beat_cnt=0.
//    Forced release at BURST_MAX: the other requester wins the next tie (last=n).
//  - OWNn with reqN_valid=0: no accept, state->IDLE, beat_cnt=0 (ownership dropped).
//  - stall_cnt: increments on each req0_valid&&!req0_ready cycle and holds at 16'hFFFF.
//    stall_clr has priority over increment and loads 0.
//  - busy = (state != IDLE), registered.
// TESTING
//  1 Reset: drive reset=0 mid-read -> rsp0_valid=0 next cycle; all outputs at reset values.
//  2 Single read: req0 rd addr=16'h0010, mem holds 16'hBEEF -> mem_en at t,
//    rsp0_valid=1 and rsp0_rdata=16'hBEEF at t+1.
//  3 Tie: both valid, no lock, held 4 cycles -> grants 0,1,0,1; stall_cnt=2.
//  4 Burst: req1 lock=1 for 6 writes while req0 waits, BURST_MAX=4 -> four req1 beats,
//    then req0 granted, then req1 resumes.
//  5 Owner drop: req1 lock beat, then req1_valid=0 for 1 cycle -> state IDLE, req0 granted next cycle.
//  6 Saturation: stall_cnt forced near 16'hFFFE, 3 stall cycles -> stays 16'hFFFF;
//    stall_clr with stall the same cycle -> 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data-memory arbiter with locked bursts and CPU stall counter
module dmem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_id,
  output logic              busy,
  input  logic              stall_clr,
  output logic [15:0]       stall_cnt
);

  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            rsp0_q, rsp1_q, grant_q;
  logic [15:0]     stall_cnt_q;
  logic            acc0, acc1, acc, win, win_lock;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        // last_q names the previous winner, so a tie goes to the other requester
        if (req0_valid && req1_valid) begin
          req0_ready = last_q;
          req1_ready = !last_q;
        end else begin
          req0_ready = req0_valid;
          req1_ready = req1_valid;
        end
      end
      OWN0:    req0_ready = req0_valid;
      OWN1:    req1_ready = req1_valid;
      default: ;
    endcase

    acc0     = req0_valid && req0_ready;
    acc1     = req1_valid && req1_ready;
    acc      = acc0 || acc1;
    win      = acc1;
    win_lock = win ? req1_lock : req0_lock;

    if (acc) begin
      mem_en    = 1'b1;
      mem_we    = win ? req1_we : req0_we;
      mem_addr  = win ? req1_addr : req0_addr;
      mem_wdata = win ? req1_wdata : req0_wdata;
      last_d    = win;
      if (win_lock && (int'(beat_cnt_q) + 1 < BURST_MAX)) begin
        state_d    = win ? OWN1 : OWN0;
        beat_cnt_d = beat_cnt_q + BW'(1);
      end else begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    end else if (state_q != IDLE) begin
      // owner withdrew its request: ownership is dropped
      state_d    = IDLE;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      beat_cnt_q  <= '0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
      grant_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      rsp0_q     <= acc0 && !req0_we;
      rsp1_q     <= acc1 && !req1_we;
      if (acc) grant_q <= win;
      if (stall_clr)
        stall_cnt_q <= '0;
      else if (req0_valid && !req0_ready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp0_rdata = mem_rdata;
  assign rsp1_rdata = mem_rdata;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int BMAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 0, req0_we = 0, req0_lock = 0;
  logic [15:0] req0_addr = '0, req0_wdata = '0;
  logic        req1_valid = 0, req1_we = 0, req1_lock = 0;
  logic [15:0] req1_addr = '0, req1_wdata = '0;
  logic        stall_clr = 0;
  logic [15:0] mem_rdata = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_rdata, rsp1_rdata, mem_addr, mem_wdata, stall_cnt;
  logic        mem_en, mem_we, grant_id, busy;

  logic [15:0] tb_mem [256];
  logic [15:0] ref_mem[256];

  logic        s_v[2], s_we[2], s_lk[2];
  logic [15:0] s_a[2], s_d[2];
  logic        s_clr;

  int          m_owner, m_beats, m_last, m_grant, m_stall;
  logic        m_rsp[2];
  logic [15:0] m_rdata;

  int          n_tests = 0;
  int          n_fail = 0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .BURST_MAX(BMAX)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy),
    .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_last = 1; m_grant = 0; m_stall = 0;
    m_rsp[0] = 0; m_rsp[1] = 0; m_rdata = '0;
  endtask

  task automatic drv(input int n, input logic v, input logic we, input logic lk,
                     input logic [15:0] a, input logic [15:0] d);
    s_v[n] = v; s_we[n] = we; s_lk[n] = lk; s_a[n] = a; s_d[n] = d;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 16'h0, 16'h0);
    drv(1, 0, 0, 0, 16'h0, 16'h0);
    s_clr = 0;
  endtask

  function automatic int pick();
    if (m_owner >= 0) return s_v[m_owner] ? m_owner : -1;
    if (s_v[0] && s_v[1]) return 1 - m_last;
    if (s_v[0]) return 0;
    if (s_v[1]) return 1;
    return -1;
  endfunction

  task automatic step();
    int w;
    @(posedge clk); #1;
    req0_valid = s_v[0]; req0_we = s_we[0]; req0_lock = s_lk[0]; req0_addr = s_a[0]; req0_wdata = s_d[0];
    req1_valid = s_v[1]; req1_we = s_we[1]; req1_lock = s_lk[1]; req1_addr = s_a[1]; req1_wdata = s_d[1];
    stall_clr = s_clr;
    @(negedge clk);
    w = pick();
    check("ready", {req1_ready, req0_ready}, (w == 1) ? 2 : ((w == 0) ? 1 : 0));
    if (w >= 0) check("mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, s_we[w], s_a[w], s_d[w]});
    else        check("mem_idle", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    check("rsp0_valid", rsp0_valid, m_rsp[0]);
    check("rsp1_valid", rsp1_valid, m_rsp[1]);
    if (m_rsp[0]) check("rsp0_rdata", rsp0_rdata, m_rdata);
    if (m_rsp[1]) check("rsp1_rdata", rsp1_rdata, m_rdata);
    check("grant_id", grant_id, m_grant);
    check("busy", busy, m_owner >= 0);
    check("stall_cnt", stall_cnt, m_stall);

    m_rsp[0] = 0; m_rsp[1] = 0;
    if (w >= 0) begin
      if (s_we[w]) ref_mem[s_a[w][7:0]] = s_d[w];
      else begin
        m_rsp[w] = 1;
        m_rdata  = ref_mem[s_a[w][7:0]];
      end
    end
    if (s_clr) m_stall = 0;
    else if (s_v[0] && w != 0 && m_stall < 65535) m_stall++;
    if (w >= 0) begin
      m_last = w; m_grant = w; m_beats++;
      if (s_lk[w] && m_beats < BMAX) m_owner = w;
      else begin m_owner = -1; m_beats = 0; end
    end else if (m_owner >= 0) begin
      m_owner = -1; m_beats = 0;
    end
  endtask

  initial begin
    int exp_burst[6];
    exp_burst = '{2, 2, 2, 2, 1, 2};
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 16'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[16] = 16'hBEEF; ref_mem[16] = 16'hBEEF;
    idle();
    model_reset();

    @(negedge clk);
    check("rst_outputs", {req0_ready, req1_ready, mem_en, mem_we, rsp0_valid, rsp1_valid, grant_id, busy, stall_cnt}, 0);
    reset = 1'b1;

    // reset asserted while a read is in flight
    drv(0, 1, 0, 0, 16'h0005, 16'h0);
    step();
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    req0_valid = 0; req1_valid = 0; stall_clr = 0;
    @(negedge clk);
    check("rst_midread_rsp0", rsp0_valid, 0);
    check("rst_midread_outs", {req0_ready, req1_ready, mem_en, rsp1_valid, grant_id, busy, stall_cnt}, 0);
    model_reset();
    reset = 1'b1;

    // tie: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 0, 16'(i + 1), 16'h0);
      drv(1, 1, 0, 0, 16'(i + 5), 16'h0);
      step();
      check("tie_ready", {req1_ready, req0_ready}, (i % 2 == 1) ? 2 : 1);
    end
    idle();
    step();
    check("tie_stall", stall_cnt, 16'd2);

    // single read
    drv(0, 1, 0, 0, 16'h0010, 16'h0);
    step();
    check("rd_mem_en", mem_en, 1);
    idle();
    step();
    check("rd_rsp_valid", rsp0_valid, 1);
    check("rd_rsp_data", rsp0_rdata, 16'hBEEF);

    // locked burst by requester 1 with requester 0 waiting
    drv(1, 1, 1, 1, 16'h0020, 16'hA000);
    step();
    check("burst_ready0", {req1_ready, req0_ready}, exp_burst[0]);
    for (int i = 1; i < 6; i++) begin
      drv(0, 1, 0, 0, 16'h0003, 16'h0);
      drv(1, 1, 1, 1, 16'(16'h20 + i), 16'(16'hA000 + i));
      step();
      check("burst_ready", {req1_ready, req0_ready}, exp_burst[i]);
    end

    // owner drop
    idle();
    drv(1, 1, 1, 1, 16'h0030, 16'h1234);
    step();
    idle();
    drv(0, 1, 0, 0, 16'h0030, 16'h0);
    step();
    check("drop_ready0_blocked", req0_ready, 0);
    step();
    check("drop_ready0_granted", req0_ready, 1);
    check("drop_busy", busy, 0);

    // stall counter saturation and clear priority
    idle();
    drv(1, 1, 1, 1, 16'h0040, 16'h5555);
    step();
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    m_stall = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 0, 16'h0001, 16'h0);
      drv(1, 1, 1, 1, 16'(16'h41 + i), 16'h6666);
      step();
    end
    idle();
    drv(1, 1, 1, 1, 16'h0050, 16'h7777);
    step();
    check("sat_hold", stall_cnt, 16'hFFFF);
    drv(0, 1, 0, 0, 16'h0002, 16'h0);
    drv(1, 1, 1, 1, 16'h0051, 16'h7778);
    s_clr = 1;
    step();
    idle();
    step();
    check("sat_clear", stall_cnt, 16'h0000);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 2; n++)
        drv(n, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 31)), 16'($urandom));
      s_clr = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
